// File: rtl/xpb_accum_ctrl_if.sv
// xpb_accum_ctrl_if: operation/result handshakes and the xpb table lookup port.
interface xpb_accum_ctrl_if #(
  parameter int NUM_SEG = 8,
  parameter int SEG_BITS = 5,
  parameter int WORD_BITS = 1024,
  parameter int ACC_BITS = WORD_BITS + 4
);
  localparam int SEL_BITS = NUM_SEG > 1 ? $clog2(NUM_SEG) : 1;
  logic in_valid;
  logic in_ready;
  logic [NUM_SEG*SEG_BITS-1:0] in_upper;
  logic [WORD_BITS-1:0] in_base;
  logic [SEL_BITS-1:0] lut_sel;
  logic [SEG_BITS-1:0] lut_addr;
  logic [WORD_BITS-1:0] lut_data;
  logic out_valid;
  logic out_ready;
  logic [ACC_BITS-1:0] out_sum;
  logic busy;
  modport master (
    output in_valid, in_upper, in_base, lut_data, out_ready,
    input in_ready, lut_sel, lut_addr, out_valid, out_sum, busy
  );
  modport slave (
    input in_valid, in_upper, in_base, lut_data, out_ready,
    output in_ready, lut_sel, lut_addr, out_valid, out_sum, busy
  );
endinterface

// File: rtl/xpb_accum_ctrl.sv
// xpb_accum_ctrl: reduces upper-bit segments one xpb table lookup per cycle into an accumulator.
module xpb_accum_ctrl #(
  parameter int NUM_SEG = 8,
  parameter int SEG_BITS = 5,
  parameter int WORD_BITS = 1024,
  parameter int ACC_BITS = WORD_BITS + 4
) (
  input logic clk,
  input logic rst_n,
  xpb_accum_ctrl_if.slave bus
);
  localparam int SEL_BITS = NUM_SEG > 1 ? $clog2(NUM_SEG) : 1;
  typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;
  state_t state_q;
  logic [ACC_BITS-1:0] acc_q;
  logic [ACC_BITS-1:0] acc_d;
  logic [SEL_BITS-1:0] seg_cnt_q;
  logic [NUM_SEG-1:0][SEG_BITS-1:0] upper_q;
  logic lookup;
  logic last;
  assign lookup = state_q == LOOKUP;
  assign last = seg_cnt_q == SEL_BITS'(NUM_SEG - 1);
  assign acc_d = acc_q + ACC_BITS'(bus.lut_data);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      seg_cnt_q <= '0;
      upper_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          upper_q <= bus.in_upper;
          acc_q <= ACC_BITS'(bus.in_base);
          seg_cnt_q <= '0;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          acc_q <= acc_d;
          seg_cnt_q <= last ? '0 : seg_cnt_q + 1'b1;
          state_q <= last ? DONE : LOOKUP;
        end
        DONE: state_q <= bus.out_ready ? IDLE : DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_sum = state_q == DONE ? acc_q : '0;
  assign bus.lut_sel = lookup ? seg_cnt_q : '0;
  assign bus.lut_addr = lookup ? upper_q[seg_cnt_q] : '0;
endmodule

// File: tb/tb_xpb_accum_ctrl.sv
// tb_xpb_accum_ctrl: vector table, corner sequences and random ops against a table-sum model.
module tb_xpb_accum_ctrl;
  localparam int W = 1024;
  localparam int A = W + 4;
  localparam int NS = 8;
  localparam int SB = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  xpb_accum_ctrl_if bus ();
  xpb_accum_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // table 0 is the shift stub, table 1 holds a*2^(W+5k) mod p
  logic [W-1:0] tbl [2][NS][32];
  logic tsel = 1'b0;
  assign bus.lut_data = tbl[tsel][bus.lut_sel][bus.lut_addr];
  int passed = 0;
  int total = 0;
  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;
  typedef struct {
    string name;
    logic [NS*SB-1:0] u;
    logic [W-1:0] b;
    logic [A-1:0] exp;
    int hold;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string n, input logic [A-1:0] act, input logic [A-1:0] exp);
    logic [A-1:0] d;
    int lo;
    total++;
    if (act === exp) passed++;
    else begin
      d = act ^ exp;
      lo = 0;
      for (int i = A - 1; i >= 0; i--) if (d[i] !== 1'b0) lo = i;
      $display("FAIL %s: from bit %0d got %h expected %h", n, lo, 64'(act >> lo), 64'(exp >> lo));
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [A-1:0] ref_sum(input logic s, input logic [NS*SB-1:0] u, input logic [W-1:0] b);
    logic [A-1:0] r;
    r = A'(b);
    for (int k = 0; k < NS; k++) r += A'(tbl[s][k][u[k*SB+:SB]]);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction

  function automatic logic [NS*SB-1:0] rnd_upper();
    logic [NS*SB-1:0] r;
    for (int k = 0; k < NS; k++) r[k*SB+:SB] = SB'($urandom_range(0, 31));
    return r;
  endfunction

  task automatic idle_chk(input string n);
    chk({n, " flags"}, A'({bus.out_valid, bus.busy, bus.in_ready, bus.lut_sel, bus.lut_addr}), A'(11'b001_000_00000));
    chk({n, " sum"}, bus.out_sum, '0);
  endtask

  task automatic add_vec(input string n, input logic [NS*SB-1:0] u, input logic [W-1:0] b,
                         input logic [A-1:0] exp, input int hold);
    vec_t v;
    v.name = n; v.u = u; v.b = b; v.exp = exp; v.hold = hold;
    vq.push_back(v);
  endtask

  task automatic run_op(input string n, input logic [NS*SB-1:0] u, input logic [W-1:0] b,
                        input logic [A-1:0] exp, input int hold);
    int cyc;
    bus.out_ready = hold == 0;
    bus.in_upper = u;
    bus.in_base = b;
    bus.in_valid = 1'b1;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin step; cyc++; end
    chk({n, " ready"}, A'(bus.in_ready), A'(1));
    step;
    bus.in_valid = 1'b0;
    bus.in_upper = ~u;
    bus.in_base = ~b;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      if (cyc < NS) chk({n, " lut"}, A'({bus.lut_sel, bus.lut_addr}), A'({3'(cyc), u[cyc*SB+:SB]}));
      step;
      cyc++;
    end
    chk({n, " latency"}, A'(cyc), A'(NS));
    chk({n, " sum"}, bus.out_sum, exp);
    for (int i = 0; i < hold; i++) begin
      step;
      chk({n, " hold"}, A'({bus.out_valid, bus.in_ready, bus.busy}), A'(3'b101));
      chk({n, " hold sum"}, bus.out_sum, exp);
    end
    bus.out_ready = 1'b1;
    step;
    idle_chk({n, " after"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NS*SB-1:0] u;
    logic [W-1:0] b;
    logic [A-1:0] e;
    logic [1099:0] p;
    int cyc, seen, last_acc;
    p = (1100'(1) << 1023) + 1100'd12345;
    for (int k = 0; k < NS; k++)
      for (int a = 0; a < 32; a++) begin
        tbl[0][k][a] = W'(a) << (8 * k);
        tbl[1][k][a] = W'((1100'(a) << (W + 5 * k)) % p);
      end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_upper = '0;
    bus.in_base = '0;
    repeat (3) step;
    idle_chk("in_reset");
    rst_n = 1'b1;
    step;
    idle_chk("post_reset");

    add_vec("zero_upper", '0, W'(16'h1234), A'(16'h1234), 0);
    add_vec("seg0_seg7", {5'd31, 30'd0, 5'd1}, '0, A'(1) + (A'(31) << 56), 0);
    add_vec("all_ones_seg", {NS{5'd1}}, '0, A'(64'h0101010101010101), 0);
    add_vec("all31_stub", {NS{5'd31}}, {W{1'b1}}, A'({W{1'b1}}) + A'(64'h1F1F1F1F1F1F1F1F), 0);
    add_vec("hold5", {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, W'(5), A'(64'h0807060504030206), 5);
    foreach (vq[i]) run_op(vq[i].name, vq[i].u, vq[i].b, vq[i].exp, vq[i].hold);

    tsel = 1'b1;
    run_op("xpb_all31", {NS{5'd31}}, {W{1'b1}}, ref_sum(1'b1, {NS{5'd31}}, {W{1'b1}}), 0);

    tsel = 1'b0;
    bus.in_upper = rnd_upper();
    bus.in_base = rnd_word();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step;
    bus.in_valid = 1'b0;
    repeat (4) step;
    rst_n = 1'b0;
    step;
    idle_chk("rst_mid");
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin step; if (bus.out_valid) seen++; end
    chk("rst_mid no result", A'(seen), '0);
    run_op("after_rst", '0, W'(7), A'(7), 0);

    bus.in_upper = rnd_upper();
    bus.in_base = rnd_word();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    step;
    bus.in_valid = 1'b0;
    repeat (NS + 2) step;
    chk("rst_done reached", A'(bus.out_valid), A'(1));
    rst_n = 1'b0;
    step;
    idle_chk("rst_done");
    rst_n = 1'b1;
    step;
    run_op("after_rst2", {NS{5'd2}}, W'(9), A'(9) + (A'(2) * A'(64'h0101010101010101)), 0);

    tsel = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    last_acc = 0;
    for (int j = 0; j < 5; j++) begin
      u = rnd_upper();
      b = rnd_word();
      e = ref_sum(1'b1, u, b);
      bus.in_upper = u;
      bus.in_base = b;
      cyc = 0;
      while (!bus.in_ready && cyc < 30) begin step; cyc++; end
      step;
      if (j > 0) chk("stream spacing", A'(ecount - last_acc), A'(NS + 2));
      last_acc = ecount;
      bus.in_upper = rnd_upper();
      bus.in_base = rnd_word();
      cyc = 0;
      while (!bus.out_valid && cyc < 30) begin step; cyc++; end
      chk("stream sum", bus.out_sum, e);
    end
    bus.in_valid = 1'b0;
    step;
    step;

    for (int j = 0; j < 16; j++) begin
      tsel = 1'($urandom_range(0, 1));
      u = rnd_upper();
      b = rnd_word();
      run_op("random", u, b, ref_sum(tsel, u, b), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
